// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle for the RV32I instruction encoder.
//   in_*  : request side (valid/ready plus decoded instruction fields)
//   out_* : response side (valid/ready plus encoded word and error status)
// master modport is the requester/consumer, slave modport is the encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [2:0]  out_err_code;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err, out_err_code
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err, out_err_code
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RV32I instruction encoder (inverse of the
// immediate generator). Stage 1 captures the request and range-checks the
// immediate; stage 2 packs the fields into the output registers, replacing
// any failing request with NOP_INST.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - imm_encoder_if.slave (request and response handshakes)
//   enc_count - completed output handshakes (wraps)
//   err_count - completed output handshakes carrying out_err=1 (wraps)
module imm_encoder #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_B  = 3'b001;
    localparam logic [2:0] FMT_J  = 3'b010;
    localparam logic [2:0] FMT_S  = 3'b011;
    localparam logic [2:0] FMT_U  = 3'b100;
    localparam logic [2:0] FMT_SH = 3'b101;

    localparam logic [2:0] ERR_NONE  = 3'b000;
    localparam logic [2:0] ERR_RANGE = 3'b001;
    localparam logic [2:0] ERR_ALIGN = 3'b010;
    localparam logic [2:0] ERR_ULOW  = 3'b011;
    localparam logic [2:0] ERR_FMT   = 3'b100;

    // True when every bit of the slice is identical, i.e. the value fits
    // when sign-extended from the slice's lowest bit.
    function automatic logic sext_ok(input logic [31:0] v, input int lsb);
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb) begin
                ones  = ones & v[i];
                zeros = zeros & ~v[i];
            end
        end
        return ones | zeros;
    endfunction

    function automatic logic [2:0] check_imm(input logic [2:0] fmt, input logic [31:0] imm);
        logic [2:0] code;
        code = ERR_NONE;
        case (fmt)
            FMT_I, FMT_S: if (!sext_ok(imm, 11)) code = ERR_RANGE;
            FMT_B: begin
                if (!sext_ok(imm, 12))  code = ERR_RANGE;
                else if (imm[0])        code = ERR_ALIGN;
            end
            FMT_J: begin
                if (!sext_ok(imm, 20))  code = ERR_RANGE;
                else if (imm[0])        code = ERR_ALIGN;
            end
            FMT_U:  if (imm[11:0] != 12'd0) code = ERR_ULOW;
            FMT_SH: if (imm[31:5] != 27'd0) code = ERR_RANGE;
            default: code = ERR_FMT;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] pack_inst(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] inst;
        case (fmt)
            FMT_I:  inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:  inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:  inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_J:  inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_U:  inst = {imm[31:12], rd, opcode};
            FMT_SH: inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            default: inst = 32'd0;
        endcase
        return inst;
    endfunction

    logic        vld_p1;
    logic        vld_p2;
    logic [2:0]  fmt_p1;
    logic [6:0]  opcode_p1;
    logic [4:0]  rd_p1;
    logic [4:0]  rs1_p1;
    logic [4:0]  rs2_p1;
    logic [2:0]  funct3_p1;
    logic [6:0]  funct7_p1;
    logic [31:0] imm_p1;
    logic [2:0]  code_p1;
    logic        advance;
    logic        accept;
    logic        fire;

    // Stage 2 can take new data when it is empty or being drained this cycle;
    // stage 1 can take a request when it is empty or moving into stage 2.
    assign advance      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || advance;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = vld_p2 && bus.out_ready;
    assign bus.out_valid = vld_p2;

    // ---- stage 1: capture request, range check ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fmt_p1    <= bus.in_fmt;
            opcode_p1 <= bus.in_opcode;
            rd_p1     <= bus.in_rd;
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            funct3_p1 <= bus.in_funct3;
            funct7_p1 <= bus.in_funct7;
            imm_p1    <= bus.in_imm;
            code_p1   <= check_imm(bus.in_fmt, bus.in_imm);
        end
    end

    // ---- stage 2: pack into output registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2           <= 1'b0;
            bus.out_inst     <= 32'd0;
            bus.out_err      <= 1'b0;
            bus.out_err_code <= ERR_NONE;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                bus.out_err_code <= code_p1;
                bus.out_err      <= (code_p1 != ERR_NONE);
                bus.out_inst     <= (code_p1 != ERR_NONE) ? NOP_INST :
                                    pack_inst(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1,
                                              funct3_p1, funct7_p1, imm_p1);
            end
        end
    end

    // ---- handshake counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (fire) begin
            enc_count <= enc_count + CNT_W'(1);
            if (bus.out_err) err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized bench for imm_encoder with a
// scoreboard-based reference model computed from immediate value ranges.
module tb_imm_encoder;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    imm_encoder_if bus();

    imm_encoder #(.CNT_W(CNT_W), .NOP_INST(32'h0000_0013)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  code;
    } exp_t;

    exp_t q[$];
    logic [CNT_W-1:0] exp_enc = '0;
    logic [CNT_W-1:0] exp_err = '0;

    // Reference model: range checks as signed intervals, packing as shifts/masks.
    function automatic exp_t model(input logic [2:0] fmt, input logic [31:0] op, rd, rs1, rs2,
                                   f3, f7, imm);
        exp_t e;
        int   s;
        s = $signed(imm);
        e.code = 3'd0;
        case (fmt)
            3'd0, 3'd3: if (s < -2048 || s > 2047) e.code = 3'd1;
            3'd1: if (s < -4096 || s > 4095) e.code = 3'd1; else if (imm % 2 != 0) e.code = 3'd2;
            3'd2: if (s < -(1 << 20) || s > (1 << 20) - 1) e.code = 3'd1;
                  else if (imm % 2 != 0) e.code = 3'd2;
            3'd4: if (imm % 4096 != 0) e.code = 3'd3;
            3'd5: if (imm > 31) e.code = 3'd1;
            default: e.code = 3'd4;
        endcase
        case (fmt)
            3'd0: e.inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd3: e.inst = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                           | ((imm & 32'h1F) << 7) | op;
            3'd1: e.inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                           | (((imm >> 11) & 1) << 7) | op;
            3'd2: e.inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                           | (rd << 7) | op;
            3'd4: e.inst = (imm & 32'hFFFF_F000) | (rd << 7) | op;
            3'd5: e.inst = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12)
                           | (rd << 7) | op;
            default: e.inst = 32'd0;
        endcase
        e.err = (e.code != 3'd0);
        if (e.err) e.inst = 32'h0000_0013;
        return e;
    endfunction

    // Compare process: one pass per falling edge.
    logic        hold = 1'b0;
    logic [31:0] hold_inst;
    logic        hold_err;
    logic [2:0]  hold_code;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_enc = '0;
            exp_err = '0;
            hold    = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_inst", bus.out_inst, 32'd0);
            chk("rst_out_err", {29'd0, bus.out_err_code}, {29'd0, 3'd0} | 32'(bus.out_err));
            chk("rst_enc_count", 32'(enc_count), 32'd0);
        end else begin
            if (hold) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_inst", bus.out_inst, hold_inst);
                chk("stall_err", {28'd0, bus.out_err, bus.out_err_code}, {28'd0, hold_err, hold_code});
            end
            chk("enc_count", 32'(enc_count), 32'(exp_enc));
            chk("err_count", 32'(err_count), 32'(exp_err));
            chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_fmt, 32'(bus.in_opcode), 32'(bus.in_rd), 32'(bus.in_rs1),
                                  32'(bus.in_rs2), 32'(bus.in_funct3), 32'(bus.in_funct7),
                                  bus.in_imm));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_inst", bus.out_inst, e.inst);
                    chk("sb_err", 32'(bus.out_err), 32'(e.err));
                    chk("sb_code", 32'(bus.out_err_code), 32'(e.code));
                    exp_enc = exp_enc + 1'b1;
                    if (e.err) exp_err = exp_err + 1'b1;
                end
            end
            hold      = bus.out_valid && !bus.out_ready;
            hold_inst = bus.out_inst;
            hold_err  = bus.out_err;
            hold_code = bus.out_err_code;
        end
    end

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
    endtask

    // Present a request and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int k;
        @(posedge clk); #1;
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (k == 20) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] ei, input logic ee,
                              input logic [2:0] ec);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'd2);
        chk({nm, "_inst"}, bus.out_inst, ei);
        chk({nm, "_err"}, 32'(bus.out_err), 32'(ee));
        chk({nm, "_code"}, 32'(bus.out_err_code), 32'(ec));
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[14];
        b = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF, 32'd4094, 32'hFFFF_F000,
              32'd4096, 32'd1048574, 32'hFFF0_0000, 32'd1048576, 32'd31, 32'd32, 32'd0, 32'd1};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return $urandom & 32'hFFFF_F000;
            default: return b[$urandom_range(0, 13)];
        endcase
    endfunction

    initial begin
        logic acc;
        int   k;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed encodings
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_out("i_addi", 32'hFFF0_0093, 1'b0, 3'd0);
        @(negedge clk);
        chk("enc_after_first", 32'(enc_count), 32'd1);
        send(3'd1, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_out("b_beq", 32'h0020_8463, 1'b0, 3'd0);
        send(3'd2, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        expect_out("j_jal", 32'h0040_00EF, 1'b0, 3'd0);
        send(3'd3, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
        expect_out("s_sw", 32'hFE20_AE23, 1'b0, 3'd0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_out("u_lui", 32'h1234_52B7, 1'b0, 3'd0);

        // Error cases
        send(3'd1, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
        expect_out("b_misalign", 32'h0000_0013, 1'b1, 3'd2);
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        expect_out("i_range", 32'h0000_0013, 1'b1, 3'd1);
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        expect_out("bad_fmt", 32'h0000_0013, 1'b1, 3'd4);
        @(negedge clk);
        chk("err_count_lit", 32'(err_count), 32'd3);
        chk("enc_count_lit", 32'(enc_count), 32'd8);

        // Backpressure: two held, third waits at the input
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk); chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(3'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2);
        @(negedge clk); chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(3'd5, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd3);
        @(negedge clk); chk("bp_ready_c", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_ready_c2", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk); chk("bp_out1", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk); chk("bp_out2", 32'(bus.out_valid), 32'd1);
        @(negedge clk); chk("bp_out3", 32'(bus.out_valid), 32'd1);
        @(negedge clk); chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !bus.in_valid) begin
                if ($urandom_range(0, 4) != 0)
                    drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
                else
                    bus.in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Reset with two requests in flight
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7);
        send(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd9);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_drop", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("post_rst_enc", 32'(enc_count), 32'd0);
        chk("post_rst_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
